qmult: RTL and testbench
========================

QMULT -- requirements
Module: qmult

Interface
REQ-001 The block SHALL have parameter Q, default 15: number of fractional bits.
REQ-002 The block SHALL have parameter N, default 32: total word width; bit N-1 is the sign, bits N-2:0 are the unsigned magnitude (integer bits N-2:Q, fraction bits Q-1:0).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port a, input, N bits: multiplicand, sign-magnitude Q-format.
REQ-006 The block SHALL have port b, input, N bits: multiplier, sign-magnitude Q-format.
REQ-007 The block SHALL have port c, output, N bits: combinational product, sign-magnitude Q-format.
REQ-008 The block SHALL have port c_reg, output, N bits: c registered on clk.
REQ-009 The block SHALL have port ovr, output, 1 bit: registered overflow flag.
REQ-010 The port order SHALL be a, b, c, clk, rst, c_reg, ovr, so that a three-port positional instance (a, b, c) remains legal.

Function
REQ-011 The magnitude product P SHALL be the full unsigned product a[N-2:0] * b[N-2:0], 2*(N-1) bits wide.
REQ-012 c[N-1] SHALL equal a[N-1] XOR b[N-1], including when the magnitude is zero (negative zero is preserved, not normalised).
REQ-013 The overflow condition SHALL be asserted when any bit of P above bit Q+N-2 is 1.
REQ-014 With no overflow, c[N-2:0] SHALL equal P[Q+N-2:Q]: fraction bits below Q are truncated toward zero in magnitude, with no rounding.
REQ-015 On overflow, c[N-2:0] SHALL saturate to all ones; the sign still follows REQ-012.
REQ-016 c SHALL be purely combinational, valid in the same delta as a and b, and independent of clk and rst.
REQ-017 On each rising clk edge with rst low, c_reg SHALL load c and ovr SHALL load the overflow condition (one-cycle latency, no handshake).
REQ-018 The parameter requirement SHALL be 1 <= Q <= N-2 and N >= 3; other values are unsupported.

Reset
REQ-019 While rst is high, c_reg SHALL be 0 and ovr SHALL be 0, taking effect immediately without waiting for a clock edge.
REQ-020 Asserting rst mid-operation SHALL clear c_reg and ovr at once while c keeps tracking a and b.
REQ-021 After rst deasserts, the first rising edge SHALL load the current c and overflow condition.

Verification (Q=23, N=32)
REQ-022 For a=0x20100000 (+64.125) and b=0x80600000 (-0.75), the bench SHALL check c=0x980C0000 (-48.09375) at once, and c_reg=0x980C0000, ovr=0 after the next edge.
REQ-023 For a=0x00800000 (+1.0) and b=0x80800000 (-1.0), the bench SHALL check c=0x80800000.
REQ-024 For a=0x20000000 (+64.0) and b=0x02000000 (+4.0), an overflow case, the bench SHALL check c=0x7FFFFFFF, and ovr=1, c_reg=0x7FFFFFFF after the edge.
REQ-025 For a=0x00000001 and b=0x00000001, the bench SHALL check c=0x00000000 (truncation).
REQ-026 For a=0x80000000 (-0) and b=0x00800000, the bench SHALL check c=0x80000000.
REQ-027 With the REQ-024 values loaded, raising rst between clock edges SHALL give c_reg=0 and ovr=0 immediately; c SHALL stay 0x7FFFFFFF; after release, the next edge SHALL reload both.

Source files
------------

// File: rtl/qmult.sv
// Sign-magnitude fixed-point multiplier with Q fractional bits.
// The product is combinational on c; c_reg and ovr capture it on each clock edge.
module qmult #(
   parameter int Q = 15,
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] c,
   input  logic         clk,
   input  logic         rst,
   output logic [N-1:0] c_reg,
   output logic         ovr
);

   localparam int MW = N - 1;
   localparam int PW = 2 * MW;

   logic [PW-1:0] mag_a;
   logic [PW-1:0] mag_b;
   logic [PW-1:0] prod;
   logic          overflow;
   logic          sign;
   logic [MW-1:0] mag_c;

   // Operands are widened first so the multiply keeps every product bit.
   assign mag_a = {{MW{1'b0}}, a[N-2:0]};
   assign mag_b = {{MW{1'b0}}, b[N-2:0]};
   assign prod  = mag_a * mag_b;

   // Any set bit above the kept window means the magnitude cannot be represented.
   assign overflow = |prod[PW-1:Q+N-1];
   assign sign     = a[N-1] ^ b[N-1];
   assign mag_c    = overflow ? {MW{1'b1}} : prod[Q+N-2:Q];
   assign c        = {sign, mag_c};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_reg <= '0;
         ovr   <= 1'b0;
      end else begin
         c_reg <= c;
         ovr   <= overflow;
      end
   end

endmodule

// File: tb/tb_qmult.sv
// Randomised and directed check of qmult (Q=23, N=32) against an arithmetic model.
module tb_qmult;

   localparam int Q = 23;
   localparam int N = 32;

   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] c;
   logic         clk;
   logic         rst;
   logic [N-1:0] c_reg;
   logic         ovr;

   int vectors = 0;
   int errors  = 0;

   qmult #(.Q(Q), .N(N)) dut (
      .a     (a),
      .b     (b),
      .c     (c),
      .clk   (clk),
      .rst   (rst),
      .c_reg (c_reg),
      .ovr   (ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Real-valued product scaled by 2^Q, truncated, saturated if above the largest magnitude.
   function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
      longint unsigned p;
      longint unsigned scaled;
      logic            ov;
      logic [N-2:0]    mag;
      p      = longint'(x[N-2:0]) * longint'(y[N-2:0]);
      scaled = p / (64'd1 << Q);
      ov     = scaled > 64'h7FFF_FFFF;
      mag    = ov ? 31'h7FFF_FFFF : scaled[N-2:0];
      return {ov, x[N-1] ^ y[N-1], mag};
   endfunction

   task automatic check_output(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive between edges, check c at once, then c_reg/ovr one edge later.
   task automatic apply_stimulus(input logic [N-1:0] x, input logic [N-1:0] y, input string tag);
      logic [N:0] m;
      m = model(x, y);
      @(negedge clk);
      a = x;
      b = y;
      #1;
      check_output({tag, " c"}, c, m[N-1:0]);
      @(posedge clk);
      #1;
      check_output({tag, " c_reg"}, c_reg, m[N-1:0]);
      check_output({tag, " ovr"}, {31'd0, ovr}, {31'd0, m[N]});
   endtask

   initial begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      rst = 1'b1;
      a   = '0;
      b   = '0;
      repeat (2) @(posedge clk);
      #1;
      a = 32'h2010_0000;
      b = 32'h8060_0000;
      #1;
      check_output("reset c_reg", c_reg, 32'h0);
      check_output("reset ovr", {31'd0, ovr}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      apply_stimulus(32'h2010_0000, 32'h8060_0000, "mixed");
      check_output("mixed const", c_reg, 32'h980C_0000);
      apply_stimulus(32'h0080_0000, 32'h8080_0000, "one_neg");
      check_output("one_neg const", c, 32'h8080_0000);
      apply_stimulus(32'h0000_0001, 32'h0000_0001, "trunc");
      check_output("trunc const", c, 32'h0000_0000);
      apply_stimulus(32'h8000_0000, 32'h0080_0000, "neg_zero");
      check_output("neg_zero const", c, 32'h8000_0000);
      apply_stimulus(32'h2000_0000, 32'h0200_0000, "sat");
      check_output("sat const", c_reg, 32'h7FFF_FFFF);
      check_output("sat ovr const", {31'd0, ovr}, 32'h1);

      // Asynchronous reset between edges clears registers while c keeps tracking.
      #3;
      rst = 1'b1;
      #1;
      check_output("async c_reg", c_reg, 32'h0);
      check_output("async ovr", {31'd0, ovr}, 32'h0);
      check_output("async c", c, 32'h7FFF_FFFF);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_output("release c_reg", c_reg, 32'h0);
      @(posedge clk);
      #1;
      check_output("reload c_reg", c_reg, 32'h7FFF_FFFF);
      check_output("reload ovr", {31'd0, ovr}, 32'h1);

      for (int i = 0; i < 60; i++) begin
         ra = $urandom;
         rb = $urandom;
         ra[N-2:0] = ra[N-2:0] >> $urandom_range(0, 24);
         rb[N-2:0] = rb[N-2:0] >> $urandom_range(0, 24);
         apply_stimulus(ra, rb, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
